dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port data memory (sync write, async read, `mem_read`-gated read data). It shares the memory between the CPU load/store unit (port 0) and the debug/program loader (port 1). It latches one winning command at a time, issues it to the memory for exactly one cycle, and returns registered read data with a valid pulse.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arbiter_rr_arb2.sv | 45 ++++
 rtl/dmem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the two-port data-memory arbiter.
//   state_e  : sequencer states (ST_IDLE, ST_ACCESS)
//   PORT_CPU : port ID of the CPU load/store unit (port 0)
//   PORT_LDR : port ID of the debug/program loader (port 1)
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester arbiter producing a one-hot winner.
// Build option: DMEM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 always
// wins contention, no last-winner input); otherwise round-robin on last_win.
// Ports:
//   req0, req1 : requests from port 0 / port 1
//   last_win   : port ID of the previous grant (round-robin build only)
//   en         : arbitration enable; no winner while low
//   win        : one-hot winner, bit 0 = port 0, bit 1 = port 1
// -----------------------------------------------------------------------------
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
`ifndef DMEM_ARB_FIXED_PRIO_EN
  input  logic       last_win,
`endif
  input  logic       en,
  output logic [1:0] win
);

  // Winner selection; a lone requester always wins.
  always_comb begin
    win = 2'b00;
    if (!en) begin
      win = 2'b00;
    end else if (req0 && req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      win = 2'b01;
`else
      // Contention goes to the port that did not win last.
      win = (last_win == PORT_LDR) ? 2'b01 : 2'b10;
`endif
    end else if (req0) begin
      win = 2'b01;
    end else if (req1) begin
      win = 2'b10;
    end else begin
      win = 2'b00;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory (sync write, async read) between the CPU
// (port 0) and the program loader (port 1). One command is latched at a time,
// driven to the memory for exactly one cycle, and read data is returned in a
// per-port register with a one-cycle valid pulse.
// Build option: DMEM_ARB_FIXED_PRIO_EN -> fixed priority (port 0 wins);
// default -> round-robin arbitration.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   reqN/weN/addrN/wdataN  : request, write enable, address, write data
//   gntN                   : one-cycle accept pulse
//   rvalidN / rdataN       : read-valid pulse / registered read data
//   mem_read, mem_write    : memory enables (0 outside the access cycle)
//   mem_addr, mem_wdata    : memory address / write data (0 outside access)
//   mem_rdata              : combinational memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                state_q, state_d;
  logic                  cmd_we_q, cmd_we_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic                  cmd_id_q, cmd_id_d;
  logic                  gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]            win;
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic                  last_q, last_d;
`endif

  rr_arb2 u_arb (
    .req0     (req0),
    .req1     (req1),
`ifndef DMEM_ARB_FIXED_PRIO_EN
    .last_win (last_q),
`endif
    .en       (state_q == ST_IDLE),
    .win      (win)
  );

  // Next-state, command latch, grant and read-return logic.
  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    cmd_id_d    = cmd_id_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win[0]) begin
          cmd_we_d    = we0;
          cmd_addr_d  = addr0;
          cmd_wdata_d = wdata0;
          cmd_id_d    = PORT_CPU;
          gnt0_d      = 1'b1;
          state_d     = ST_ACCESS;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last_d      = PORT_CPU;
`endif
        end else if (win[1]) begin
          cmd_we_d    = we1;
          cmd_addr_d  = addr1;
          cmd_wdata_d = wdata1;
          cmd_id_d    = PORT_LDR;
          gnt1_d      = 1'b1;
          state_d     = ST_ACCESS;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last_d      = PORT_LDR;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // Requests are ignored here; the access always lasts one cycle.
        state_d = ST_IDLE;
        if (!cmd_we_q) begin
          if (cmd_id_q == PORT_CPU) begin
            rdata0_d  = mem_rdata;
            rvalid0_d = 1'b1;
          end else begin
            rdata1_d  = mem_rdata;
            rvalid1_d = 1'b1;
          end
        end else begin
          rvalid0_d = 1'b0;
          rvalid1_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and command registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_id_q    <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_q      <= PORT_LDR;
`endif
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      cmd_id_q    <= cmd_id_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  // Memory drive: only during ACCESS; the write enable is gated by rst_n so a
  // reset landing on the access cycle cannot commit the write.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == ST_ACCESS) begin
      mem_read  = ~cmd_we_q;
      mem_write = cmd_we_q & rst_n;
      mem_addr  = cmd_addr_q;
      mem_wdata = cmd_wdata_q;
    end else begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed and randomized stimulus for dmem_arbiter against a reference model
// (memory array, per-port read registers, previous-winner port). Honors
// DMEM_ARB_FIXED_PRIO_EN for the expected contention winner.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [3:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        mem_read, mem_write;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  // Memory instance the arbiter drives: sync write, async read gated by mem_read.
  logic [15:0] bmem [16];
  assign mem_rdata = mem_read ? bmem[mem_addr] : 16'h0000;
  always @(posedge clk) if (mem_write) bmem[mem_addr] <= mem_wdata;

  // Reference model state.
  logic [15:0] ref_mem [16];
  logic [15:0] ref_rdata [2];
  int          last_win;

  int vectors = 0;
  int errors  = 0;

  dmem_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (last_win == 1) ? 0 : 1;
`endif
    end
    return r0 ? 0 : 1;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt0"}, 32'(gnt0), 32'd0);
    chk({tag, "_gnt1"}, 32'(gnt1), 32'd0);
    chk({tag, "_rvalid0"}, 32'(rvalid0), 32'd0);
    chk({tag, "_rvalid1"}, 32'(rvalid1), 32'd0);
    chk({tag, "_rdata0"}, 32'(rdata0), 32'd0);
    chk({tag, "_rdata1"}, 32'(rdata1), 32'd0);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  // One arbitration round starting in IDLE, called #1 after a rising edge.
  task automatic step(input string tag,
                      input bit r0, input bit w0, input logic [3:0] a0, input logic [15:0] d0,
                      input bit r1, input bit w1, input logic [3:0] a1, input logic [15:0] d1,
                      input bit hold);
    int          win;
    bit          we;
    logic [3:0]  a;
    logic [15:0] d;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(posedge clk); #1;
    if (!r0 && !r1) begin
      chk({tag, "_idle_gnt0"}, 32'(gnt0), 32'd0);
      chk({tag, "_idle_gnt1"}, 32'(gnt1), 32'd0);
      chk({tag, "_idle_mem_read"}, 32'(mem_read), 32'd0);
      chk({tag, "_idle_mem_addr"}, 32'(mem_addr), 32'd0);
      return;
    end
    win = pick(r0, r1);
    we  = (win == 0) ? w0 : w1;
    a   = (win == 0) ? a0 : a1;
    d   = (win == 0) ? d0 : d1;
    chk({tag, "_gnt0"}, 32'(gnt0), 32'(win == 0));
    chk({tag, "_gnt1"}, 32'(gnt1), 32'(win == 1));
    chk({tag, "_mem_write"}, 32'(mem_write), 32'(we));
    chk({tag, "_mem_read"}, 32'(mem_read), 32'(!we));
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(d));
    last_win = win;
    if (!hold) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    @(posedge clk); #1;
    if (we) ref_mem[a] = d;
    else    ref_rdata[win] = ref_mem[a];
    chk({tag, "_rvalid0"}, 32'(rvalid0), 32'(!we && win == 0));
    chk({tag, "_rvalid1"}, 32'(rvalid1), 32'(!we && win == 1));
    chk({tag, "_rdata0"}, 32'(rdata0), 32'(ref_rdata[0]));
    chk({tag, "_rdata1"}, 32'(rdata1), 32'(ref_rdata[1]));
    chk({tag, "_idle_mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_gnt_done"}, 32'(gnt0 | gnt1), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      bmem[i]    = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    ref_rdata[0] = 16'h0000;
    ref_rdata[1] = 16'h0000;
    last_win     = 1;

    // Reset held for two cycles with both requests high.
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd0; wdata0 = 16'h0000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd0; wdata1 = 16'h0000;
    @(posedge clk); #1;
    check_all_zero("rst1");
    @(posedge clk); #1;
    check_all_zero("rst2");
    rst_n = 1'b1;

    // First contention after reset goes to port 0.
    step("first", 1'b1, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 4'd0, 16'h0, 1'b0);

    // Port 0 write then read of addr 3.
    step("wr3", 1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    step("rd3", 1'b1, 1'b0, 4'd3, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);

    // Both ports hold read requests continuously.
    for (int i = 0; i < 4; i++)
      step("alt", 1'b1, 1'b0, 4'd3, 16'h0, 1'b1, 1'b0, 4'd7, 16'h0, 1'b1);
    req0 = 1'b0; req1 = 1'b0;

    // Port 1 writes addr 15, port 0 reads it back.
    step("wr15", 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b1, 4'd15, 16'h1234, 1'b0);
    step("rd15", 1'b1, 1'b0, 4'd15, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);

    // Reset during the access cycle of a port 1 write to addr 5.
    step("wr5", 1'b1, 1'b1, 4'd5, 16'h5555, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    req1 = 1'b1; we1 = 1'b1; addr1 = 4'd5; wdata1 = 16'hAAAA;
    @(posedge clk); #1;
    chk("mid_rst_gnt1", 32'(gnt1), 32'd1);
    rst_n = 1'b0;
    req1 = 1'b0;
    #1;
    chk("mid_rst_mem_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_all_zero("mid_rst_after");
    last_win     = 1;
    ref_rdata[0] = 16'h0000;
    ref_rdata[1] = 16'h0000;
    step("rd5", 1'b1, 1'b0, 4'd5, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);

    // Back-to-back boundary reads by port 0.
    step("wr0", 1'b1, 1'b1, 4'd0, 16'h0F0F, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    step("bb0", 1'b1, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    step("bb15", 1'b1, 1'b0, 4'd15, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      step("rnd",
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 16'($urandom),
           1'($urandom_range(0, 1)));
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
